serial_subtractor_4bit: RTL and testbench

Bit-serial subtractor computing d = a − b − bin over WIDTH clock cycles. It uses one 1-bit subtract cell, a borrow flop and shift registers instead of a ripple chain. It is the inverse arithmetic companion to the 4-bit ripple adder in the combinational library. It sits behind valid/ready handshakes so it can be chained after the adder for add-then-undo round-trip checks.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/full_subtractor_1bit.sv | 18 +
 rtl/serial_subtractor_4bit.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The state encoding, default operand width and counter sizing live here
// so that the top and any wrapper agree on them.
package serial_sub_pkg;

    // Control states: wait for operands, process one bit per cycle, hold result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bit counter width; never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational; the serial datapath reuses this single cell
// every cycle instead of building a ripple chain.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for one bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: d = a - b - bin over WIDTH clock cycles.
// Operands are accepted through a valid/ready handshake, shifted LSB-first
// through a single full_subtractor_1bit cell, and the result is held behind
// an output valid/ready handshake. One job in flight at a time.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_4bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor_1bit u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state and datapath update for accept, per-bit shift and result hold
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
`ifdef SUB_OVF_EN
        a_msb_d = a_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // New difference bit enters at the MSB so the LSB-first
                // sequence lands in natural order after WIDTH shifts
                res_d = {cell_d, res_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = cell_bout;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SUB_OVF_EN
                    // On the last bit the shift LSB of b is its original MSB
                    ovf_d = (a_msb_q != b_q[0]) && (cell_d != a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef SUB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SUB_OVF_EN
    // Overflow capture: accepted minuend MSB and the registered flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            ovf_q   <= ovf_d;
        end
    end
`endif

    // Outputs are decoded from registers only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        d         = res_q;
        bout      = br_q;
`ifdef SUB_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed testbench for serial_subtractor_4bit (WIDTH=4).
// Define SUB_OVF_EN to build and check the overflow output as well.
module tb_serial_subtractor_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] d;
    logic       bout;
`ifdef SUB_OVF_EN
    logic       ovf;
`endif

    int n_checks;
    int n_fail;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge (caller ensures in_ready is high)
    task automatic start_job(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 4'hx;
        b        = 4'hx;
        bin      = 1'bx;
    endtask

    // Count edges after accept until out_valid, bounded at 20
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 4'h0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b d=%b bout=%b, required 1 0 0000 0",
                     in_ready, out_valid, d, bout);
        end
`ifdef SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: ovf=%b required 0", ovf);
        end
`endif
    endtask

    task automatic test_basic();
        logic [3:0] va   [3] = '{4'b1001, 4'b0011, 4'b0000};
        logic [3:0] vb   [3] = '{4'b0011, 4'b1001, 4'b0000};
        logic       vbin [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] ed   [3] = '{4'b0110, 4'b1010, 4'b1111};
        logic       eb   [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            start_job(va[i], vb[i], vbin[i]);
            wait_valid(lat);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, required 4", i, lat);
            end
            n_checks++;
            if (d !== ed[i] || bout !== eb[i]) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: d=%b bout=%b, required d=%b bout=%b",
                         i, d, bout, ed[i], eb[i]);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: in_ready=%b required 0", i, in_ready);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_pop[%0d]: out_valid=%b in_ready=%b, required 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        // 12 - 5 - 1 = 6
        out_ready = 1'b0;
        start_job(4'b1100, 4'b0101, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 4'b0001;
            b        = 4'b1110;
            bin      = 1'b0;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== 4'b0110 || bout !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b d=%b bout=%b, required 1 0 0110 0",
                         i, out_valid, in_ready, d, bout);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_ghost: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        // 0 - 1 leaves nonzero partial result bits in flight
        start_job(4'b0000, 4'b0001, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 4'h0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b d=%b bout=%b, required 1 0 0000 0",
                     in_ready, out_valid, d, bout);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        out_ready = 1'b0;
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        int lat;
        out_ready = 1'b0;
        start_job(4'b0111, 4'b1000, 1'b0);
        wait_valid(lat);
        n_checks++;
        if (d !== 4'b1111 || bout !== 1'b1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: d=%b bout=%b ovf=%b, required 1111 1 1", d, bout, ovf);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b required 0 after pop", ovf);
        end
        out_ready = 1'b0;
        start_job(4'b0101, 4'b0011, 1'b0);
        wait_valid(lat);
        n_checks++;
        if (d !== 4'b0010 || bout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_none: d=%b bout=%b ovf=%b, required 0010 0 0", d, bout, ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_exhaustive();
        int sent, got, cyc;
        logic acc, pop;
        logic [3:0] ea, eb;
        logic       ebin;
        logic [4:0] expv;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 512 && cyc < 20000) begin
            if (sent < 512) begin
                in_valid = 1'b1;
                a        = sent[3:0];
                b        = sent[7:4];
                bin      = sent[8];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                ea   = got[3:0];
                eb   = got[7:4];
                ebin = got[8];
                expv = {1'b0, ea} - {1'b0, eb} - {4'b0, ebin};
                n_checks++;
                if ({bout, d} !== expv) begin
                    n_fail++;
                    $display("FAIL exh[%0d] a=%b b=%b bin=%b: {bout,d}=%b required %b",
                             got, ea, eb, ebin, {bout, d}, expv);
                end
                got++;
            end
            if (acc) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (sent !== 512 || got !== 512) begin
            n_fail++;
            $display("FAIL exh_count: jobs in=%0d out=%0d, required 512 512", sent, got);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        bin       = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_backpressure();
        test_reset_mid();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
